// File: rtl/modulo_counter_core.sv
// Loadable up/down modulo counter with range-checked loads and a FAULT state.
// Define COUNTER_CORE_SELFWRAP_EN to make boundary steps wrap MAX_VAL<->MIN_VAL.
module modulo_counter_core #(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 1,
    parameter int MAX_VAL = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             load_ack,
    output logic             err
);

    localparam logic [WIDTH-1:0] MIN_Q = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt, ack_nxt, err_nxt;
    logic             load_legal, at_bound, step;

    function automatic logic in_range(input logic [WIDTH-1:0] v);
        return (v >= MIN_Q) && (v <= MAX_Q);
    endfunction

    // Plain modulo-2^WIDTH step; boundary handling is layered on top.
    function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] cur,
                                                    input logic down);
        return down ? (cur - ONE_Q) : (cur + ONE_Q);
    endfunction

    assign load_legal = in_range(d);
    assign at_bound   = dir ? (q == MIN_Q) : (q == MAX_Q);
    assign step       = enable & ~load & (state != FAULT);
    assign tc         = step & at_bound;

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        wrap_nxt  = 1'b0;
        ack_nxt   = 1'b0;
        if (load) begin
            if (load_legal) begin
                q_nxt     = d;
                state_nxt = COUNT;
                ack_nxt   = 1'b1;
            end else begin
                state_nxt = FAULT;
            end
        end else if (step) begin
            q_nxt = step_value(q, dir);
`ifdef COUNTER_CORE_SELFWRAP_EN
            if (at_bound) begin
                q_nxt = dir ? MAX_Q : MIN_Q;
            end
`endif
            state_nxt = COUNT;
            wrap_nxt  = at_bound;
        end
        err_nxt = (state_nxt == FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            q        <= MIN_Q;
            wrap     <= 1'b0;
            load_ack <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            q        <= q_nxt;
            wrap     <= wrap_nxt;
            load_ack <= ack_nxt;
            err      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_modulo_counter_core.sv
// Randomized and directed bench for modulo_counter_core against an arithmetic model.
module tb_modulo_counter_core;

    localparam int W    = 4;
    localparam int MINV = 1;
    localparam int MAXV = 12;
    localparam int MODV = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable, load, dir;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         tc, wrap, load_ack, err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: the count as a plain integer plus a "faulted" flag and pulse flags.
    int m_q;
    bit m_fault, m_wrap, m_ack;

    modulo_counter_core #(.WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .d(d), .dir(dir),
        .q(q), .tc(tc), .wrap(wrap), .load_ack(load_ack), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_at_bound();
        return dir ? (m_q == MINV) : (m_q == MAXV);
    endfunction

    function automatic bit model_tc();
        return enable && !load && !m_fault && model_at_bound();
    endfunction

    task automatic model_reset();
        m_q = MINV; m_fault = 0; m_wrap = 0; m_ack = 0;
    endtask

    task automatic model_edge();
        bit b;
        b = model_at_bound();
        m_wrap = 0;
        m_ack  = 0;
        if (load) begin
            if (int'(d) >= MINV && int'(d) <= MAXV) begin
                m_q = int'(d); m_fault = 0; m_ack = 1;
            end else begin
                m_fault = 1;
            end
        end else if (enable && !m_fault) begin
            m_wrap = b;
`ifdef COUNTER_CORE_SELFWRAP_EN
            if (b) m_q = dir ? MAXV : MINV;
            else   m_q = dir ? (m_q + MODV - 1) % MODV : (m_q + 1) % MODV;
`else
            m_q = dir ? (m_q + MODV - 1) % MODV : (m_q + 1) % MODV;
`endif
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},        32'(q),        32'(m_q));
        check({tag, ".wrap"},     32'(wrap),     32'(m_wrap));
        check({tag, ".load_ack"}, 32'(load_ack), 32'(m_ack));
        check({tag, ".err"},      32'(err),      32'(m_fault));
        check({tag, ".tc"},       32'(tc),       32'(model_tc()));
    endtask

    // Apply inputs at the falling edge, compare, then advance model and DUT one edge.
    task automatic cyc(input bit en, input bit ld, input int dv, input bit dr, input string tag);
        enable = en; load = ld; d = W'(dv); dir = dr;
        #1;
        check_all(tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Async reset pulse placed between clock edges, checked before any edge arrives.
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        check({tag, ".q"},        32'(q),        32'(MINV));
        check({tag, ".err"},      32'(err),      32'd0);
        check({tag, ".wrap"},     32'(wrap),     32'd0);
        check({tag, ".load_ack"}, 32'(load_ack), 32'd0);
        @(negedge clk);
        enable = 0; load = 0; dir = 0; d = '0;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1; enable = 0; load = 0; dir = 0; d = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check("rst.q", 32'(q), 32'd1);
        check("rst.tc", 32'(tc), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        check_all("rst");

        // Mid-count async reset at q=7, then again from FAULT.
        cyc(0, 1, 5, 0, "ld5");
        cyc(1, 0, 0, 0, "up6");
        cyc(1, 0, 0, 0, "up7");
        check("mid.q7", 32'(q), 32'd7);
        async_reset("arst_cnt");
        cyc(0, 1, 14, 0, "ld14f");
        check("flt.err", 32'(err), 32'd1);
        async_reset("arst_flt");

        // Illegal load holds q, enable ignored, legal load recovers.
        cyc(0, 1, 5, 0, "ld5b");
        cyc(0, 1, 14, 0, "ld14");
        check("ill.q", 32'(q), 32'd5);
        check("ill.err", 32'(err), 32'd1);
        check("ill.ack", 32'(load_ack), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, i[0], "flt_en");
        check("flt.q", 32'(q), 32'd5);
        cyc(0, 1, 3, 0, "ld3");
        check("rec.q", 32'(q), 32'd3);
        check("rec.err", 32'(err), 32'd0);
        check("rec.ack", 32'(load_ack), 32'd1);

        // Load and enable together at the top boundary: load wins.
        cyc(0, 1, 12, 0, "ld12");
        enable = 1; load = 0; #1;
        check("top.tc", 32'(tc), 32'd1);
        cyc(1, 1, 9, 0, "ld9en");
        check("ldw.q", 32'(q), 32'd9);
        check("ldw.wrap", 32'(wrap), 32'd0);
        check("ldw.ack", 32'(load_ack), 32'd1);

        // Controller-style reload on tc from q=11.
        cyc(0, 1, 11, 0, "ld11");
        cyc(1, 0, 0, 0, "up12");
        check("tcl.q12", 32'(q), 32'd12);
        cyc(1, 1, 1, 0, "tcload");
        check("tcl.q", 32'(q), 32'd1);
        check("tcl.wrap", 32'(wrap), 32'd0);
        check("tcl.ack", 32'(load_ack), 32'd1);

`ifdef COUNTER_CORE_SELFWRAP_EN
        for (int i = 0; i < 11; i++) cyc(1, 0, 0, 0, "sw_up");
        check("swu.q12", 32'(q), 32'd12);
        cyc(1, 0, 0, 0, "sw_top");
        check("swu.q1", 32'(q), 32'd1);
        check("swu.wrap", 32'(wrap), 32'd1);
        cyc(0, 1, 2, 1, "ld2");
        cyc(1, 0, 0, 1, "sw_dn");
        check("swd.q1", 32'(q), 32'd1);
        cyc(1, 0, 0, 1, "sw_bot");
        check("swd.q12", 32'(q), 32'd12);
        check("swd.wrap", 32'(wrap), 32'd1);
`else
        cyc(0, 1, 12, 0, "ld12n");
        cyc(1, 0, 0, 0, "nw_up");
        check("nwu.q13", 32'(q), 32'd13);
        check("nwu.wrap", 32'(wrap), 32'd1);
        cyc(0, 1, 1, 1, "ld1n");
        cyc(1, 0, 0, 1, "nw_dn");
        check("nwd.q0", 32'(q), 32'd0);
        check("nwd.wrap", 32'(wrap), 32'd1);
`endif

        // Randomized traffic, including out-of-range loads and direction flips.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset("rnd_rst");
            end else begin
                cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                    int'($urandom_range(0, MODV - 1)), $urandom_range(0, 3) == 0, "rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/modulo_counter_core.md
# modulo_counter_core

Loadable modulo counter that sits on the receiving end of the enable/load/data counter-control interface driven by the design's counter controllers, e.g. the 1–12 sequencer. It executes the controller's commands, applies an up/down step, and reports range boundaries back to the controller. It also checks every load against the legal range and holds a fault state until a legal value is loaded.

## Interface
- WIDTH, 4, counter and load-data width in bits
- MIN_VAL, 1, lowest legal count (reset value)
- MAX_VAL, 12, highest legal count; MIN_VAL < MAX_VAL < 2^WIDTH
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  step request for this cycle
- load  input  1  load request; d is sampled this cycle
- d  input  WIDTH  load value
- dir  input  1  0 = count up, 1 = count down
- q  output  WIDTH  current count, registered
- tc  output  1  combinational terminal count: enable & ~load & counting & q at boundary (MAX_VAL up, MIN_VAL down)
- wrap  output  1  registered one-cycle pulse following a boundary step
- load_ack  output  1  registered one-cycle pulse following an accepted legal load
- err  output  1  registered; high while in FAULT

## Operation
- Clock is clk. Reset is asynchronous and active-high, named reset.
- States:
  - IDLE: after reset.
  - COUNT: entered on the first enable or legal load.
  - FAULT: entered on any load with d < MIN_VAL or d > MAX_VAL, from any state.
- Command priority per cycle: load over enable.
- Legal load: q <= d, state -> COUNT, load_ack = 1 next cycle.
- Illegal load: q holds, state -> FAULT, err = 1 next cycle, no load_ack.
- In FAULT:
  - enable is ignored, q holds, tc = 0.
  - Only a legal load exits, to COUNT. err clears in the same edge that sets load_ack.
- Step (enable & ~load, state IDLE or COUNT):
  - Up: q+1. Down: q−1.
  - At the boundary, the result follows the Configuration section.
  - wrap = 1 the next cycle.
- Arithmetic is modulo 2^WIDTH. No other saturation.
- dir is sampled every cycle. A direction change takes effect on that cycle's step.
- q outside [MIN_VAL, MAX_VAL] is reachable only without the macro. tc still compares against the boundary values.

## Timing
- Reset values: q = MIN_VAL, wrap = 0, load_ack = 0, err = 0, state IDLE. tc = 0 because IDLE/COUNT with q = MIN_VAL, up.
- Latency from command to q update: 1 cycle.
- wrap, load_ack and err each change one cycle after the causing edge. Pulses last exactly one cycle unless the cause repeats.
- tc is valid in the same cycle as enable. The controller uses it to assert load on that same cycle. A same-cycle load suppresses tc and the wrap.
- Simultaneous load and enable at the boundary: the load wins, and wrap stays 0.
- Reset asserted mid-operation: all outputs reach their reset values immediately, without waiting for clk. The first command is accepted on the first rising edge after reset deasserts.

## Configuration
- COUNTER_CORE_SELFWRAP_EN defined:
  - Up step from MAX_VAL gives MIN_VAL. Down step from MIN_VAL gives MAX_VAL.
  - wrap pulses on these steps.
- Undefined:
  - The counter never self-wraps. Up from MAX_VAL gives MAX_VAL+1; down from MIN_VAL gives MIN_VAL−1 (mod 2^WIDTH).
  - wrap still pulses after any step taken from a boundary value.
  - The controller must load on tc to keep q in range.

## Test plan
- Reset pulse asynchronous to clk, mid-count at q=7 → q=1 and err=0 immediately, without waiting for a clk edge.
- Up, enable held, from q=1, with SELFWRAP_EN → sequence 2..12, then 1. tc high while q=12. wrap high the cycle after q returns to 1.
- Without macro: enable held with load=tc, d=1, from q=11 → 12, then 1. wrap=0, load_ack=1 after the load.
- load d=14 at q=5 → q holds 5, err=1 next cycle. Enable ignored for 3 cycles. load d=3 → q=3, err=0, load_ack=1.
- Down with SELFWRAP_EN, from q=2, enable held → 1, then 12. tc high at q=1.
- load d=9 and enable in the same cycle at q=12 → q=9, wrap=0, tc=0, load_ack=1.
